if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, PC+4 incrementer, instruction-memory address drive, and the IF/ID pipeline register.
- Sits directly upstream of the hazard/stall unit.
- Consumes that unit's PC_WriteEn and IFID_WriteEn outputs to freeze fetch on a load-use hazard.
- Also takes the branch redirect from the ID/EX side and converts it into an IF/ID flush (NOP bubble).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on flush (sll $0,$0,0)
- CNT_W, 16, width of the optional stall counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- PC_WriteEn  input  1  1 = PC may advance; 0 = hold PC (load-use stall)
- IFID_WriteEn  input  1  1 = IF/ID may capture; 0 = hold IF/ID
- Branch_taken  input  1  redirect request, valid for this cycle only
- Branch_target  input  32  redirect address
- imem_data  input  32  instruction word at imem_addr (combinational memory)
- imem_addr  output  32  current PC
- IFID_instr  output  32  registered instruction to ID
- IFID_pc4  output  32  registered PC+4 of IFID_instr
- IFID_valid  output  1  1 = IFID_instr is a real fetched instruction, 0 = bubble
- stall_cycles  output  CNT_W  stall statistics (see Optional Feature)

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-low on rst_n; all registers clear immediately on assertion.
- Reset values:
  - PC = RESET_PC, so imem_addr = RESET_PC.
  - IFID_instr = NOP_INSTR, IFID_pc4 = 0, IFID_valid = 0, stall_cycles = 0.
- First fetch is captured on the first rising edge after rst_n deasserts.
- Reset asserted mid-stall or mid-redirect discards all pending state; no held value survives.
- imem_addr = PC, combinational from the PC register, zero latency.
- pc_plus4 = PC + 32'd4, modulo 2^32: PC 32'hFFFF_FFFC wraps to 0 with no error flag.
- PC update each rising edge, in priority order:
  1. Branch_taken = 1: PC <= {Branch_target[31:2], 2'b00}. This overrides PC_WriteEn = 0, because the younger stalled instruction is being squashed anyway.
  2. Else if PC_WriteEn = 1: PC <= pc_plus4.
  3. Else: PC holds.
- IF/ID update each rising edge, in priority order:
  1. Branch_taken = 1 (flush): IFID_instr <= NOP_INSTR, IFID_pc4 <= 0, IFID_valid <= 0. Overrides IFID_WriteEn = 0.
  2. Else if IFID_WriteEn = 1: IFID_instr <= imem_data, IFID_pc4 <= pc_plus4, IFID_valid <= 1.
  3. Else: all three hold their values.
- Fetch-to-ID latency: one cycle.
- Redirect timing: a redirect on cycle N gives imem_addr = target on cycle N+1, one bubble in ID on cycle N+1, and the target instruction in ID on cycle N+2.
- PC_WriteEn and IFID_WriteEn are sampled independently.
  - PC held with IF/ID writing re-captures the same instruction (legal, no check).
  - PC advancing with IF/ID held drops the fetched word (legal, caller's responsibility).
- Stall lasting several cycles: PC and IF/ID stay frozen for every cycle the enables stay low; no internal timeout.
- No X propagation: imem_data is captured verbatim; a flush never reads imem_data.

Optional Feature:
- Macro: IF_STALL_COUNT_EN.
- Defined:
  - stall_cycles increments by 1 on each rising edge with PC_WriteEn = 0 and Branch_taken = 0.
  - It saturates at all-ones (no wrap) and clears only on reset.
- Undefined:
  - No counter register is built; stall_cycles is tied to 0.
  - The port list is unchanged.

Test Plan:
- Reset: hold rst_n = 0 with clk running, then release; imem_data = 32'h2008_0005 -> IFID_valid = 0, imem_addr = 0 while in reset. After the first edge: IFID_instr = 32'h2008_0005, IFID_pc4 = 4, imem_addr = 4.
- Straight-line fetch: both enables = 1 for 4 edges -> imem_addr steps 0, 4, 8, 12, 16; IFID_pc4 tracks 4, 8, 12, 16.
- Load-use stall: at PC = 8, drive PC_WriteEn = IFID_WriteEn = 0 for 2 edges -> imem_addr stays 8 and IFID_instr/pc4 hold. Re-enable -> PC = 12 on the next edge. With IF_STALL_COUNT_EN, stall_cycles = 2.
- Branch over stall: PC = 12, PC_WriteEn = IFID_WriteEn = 0, Branch_taken = 1, Branch_target = 32'h0000_0043 -> next edge: imem_addr = 32'h40, IFID_valid = 0, IFID_instr = NOP_INSTR. stall_cycles does not increment.
- Wrap: force the PC to 32'hFFFF_FFFC via a redirect, then advance with both enables = 1 -> imem_addr = 0, IFID_pc4 = 0.
- Async reset mid-stall: assert rst_n = 0 between edges while stalled at PC = 8 -> imem_addr = 0, IFID_valid = 0, stall_cycles = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, PC+4, imem address drive and IF/ID register.
// Optional stall statistics counter built only when IF_STALL_COUNT_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PC_WriteEn,
    input  logic             IFID_WriteEn,
    input  logic             Branch_taken,
    input  logic [31:0]      Branch_target,
    input  logic [31:0]      imem_data,
    output logic [31:0]      imem_addr,
    output logic [31:0]      IFID_instr,
    output logic [31:0]      IFID_pc4,
    output logic             IFID_valid,
    output logic [CNT_W-1:0] stall_cycles
);

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic [31:0] pc_p0;
    logic [31:0] pc_plus4_p0;
    logic [31:0] pc_next_p0;

    logic [31:0] ifid_instr_p1;
    logic [31:0] ifid_pc4_p1;
    logic        vld_p1;

    // ---- stage 0: fetch ----
    assign pc_plus4_p0 = pc_p0 + 32'd4;
    assign imem_addr   = pc_p0;

    always_comb begin
        pc_next_p0 = pc_p0;
        if (Branch_taken)
            pc_next_p0 = word_align(Branch_target);
        else if (PC_WriteEn)
            pc_next_p0 = pc_plus4_p0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_p0 <= RESET_PC;
        else
            pc_p0 <= pc_next_p0;
    end

    // ---- stage 1: IF/ID register; a flush never looks at imem_data ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr_p1 <= NOP_INSTR;
            ifid_pc4_p1   <= 32'd0;
            vld_p1        <= 1'b0;
        end else if (Branch_taken) begin
            ifid_instr_p1 <= NOP_INSTR;
            ifid_pc4_p1   <= 32'd0;
            vld_p1        <= 1'b0;
        end else if (IFID_WriteEn) begin
            ifid_instr_p1 <= imem_data;
            ifid_pc4_p1   <= pc_plus4_p0;
            vld_p1        <= 1'b1;
        end
    end

    assign IFID_instr = ifid_instr_p1;
    assign IFID_pc4   = ifid_pc4_p1;
    assign IFID_valid = vld_p1;

`ifdef IF_STALL_COUNT_EN
    // A redirect cycle is not a stall even if the PC enable is low.
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (!PC_WriteEn && !Branch_taken)
            stall_cnt <= sat_inc(stall_cnt);
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed-vector bench for if_stage: table of per-edge vectors plus reset/saturation sequences.
module tb_if_stage;

`ifdef IF_STALL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PC_WriteEn = 1'b1;
    logic        IFID_WriteEn = 1'b1;
    logic        Branch_taken = 1'b0;
    logic [31:0] Branch_target = 32'd0;
    logic [31:0] imem_data = 32'h2008_0005;
    logic [31:0] imem_addr, IFID_instr, IFID_pc4;
    logic        IFID_valid;
    logic [15:0] stall_cycles;
    logic [31:0] s_imem_addr, s_instr, s_pc4;
    logic        s_valid;
    logic [2:0]  s_stall;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .PC_WriteEn(PC_WriteEn), .IFID_WriteEn(IFID_WriteEn),
        .Branch_taken(Branch_taken), .Branch_target(Branch_target), .imem_data(imem_data),
        .imem_addr(imem_addr), .IFID_instr(IFID_instr), .IFID_pc4(IFID_pc4),
        .IFID_valid(IFID_valid), .stall_cycles(stall_cycles)
    );

    if_stage #(.CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .PC_WriteEn(PC_WriteEn), .IFID_WriteEn(IFID_WriteEn),
        .Branch_taken(Branch_taken), .Branch_target(Branch_target), .imem_data(imem_data),
        .imem_addr(s_imem_addr), .IFID_instr(s_instr), .IFID_pc4(s_pc4),
        .IFID_valid(s_valid), .stall_cycles(s_stall)
    );

    typedef struct {
        logic        pc_we;
        logic        ifid_we;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] imem;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input logic [15:0] c);
        return CNT_EN ? c : 16'd0;
    endfunction

    initial begin
        //            pc  ifid br  tgt            imem           addr           instr          pc4            v  stall
        vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h2008_0005, 32'h4,         32'h2008_0005, 32'h4,         1'b1, 16'd0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h1111_0004, 32'h8,         32'h1111_0004, 32'h8,         1'b1, 16'd0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h2222_0008, 32'h8,         32'h1111_0004, 32'h8,         1'b1, 16'd1};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h2222_0008, 32'h8,         32'h1111_0004, 32'h8,         1'b1, 16'd2};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h2222_0008, 32'hC,         32'h2222_0008, 32'hC,         1'b1, 16'd2};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 32'h43,        32'h3333_000C, 32'h40,        32'h0,         32'h0,         1'b0, 16'd2};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h4444_0040, 32'h44,        32'h4444_0040, 32'h44,        1'b1, 16'd2};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0, 16'd2};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h5555_FFFC, 32'h0,         32'h5555_FFFC, 32'h0,         1'b1, 16'd2};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h6666_0000, 32'h0,         32'h6666_0000, 32'h4,         1'b1, 16'd3};
        vt[10] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h7777_0000, 32'h4,         32'h6666_0000, 32'h4,         1'b1, 16'd3};
        vt[11] = '{1'b1, 1'b1, 1'b1, 32'h100,       32'hCAFE_0004, 32'h100,       32'h0,         32'h0,         1'b0, 16'd3};
        vt[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8888_0100, 32'h104,       32'h0,         32'h0,         1'b0, 16'd3};

        // reset held across clock edges
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", {31'd0, IFID_valid}, 32'h0);
        check("rst_instr", IFID_instr, 32'h0);
        check("rst_pc4",   IFID_pc4, 32'h0);
        check("rst_stall", {16'd0, stall_cycles}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            PC_WriteEn    = vt[i].pc_we;
            IFID_WriteEn  = vt[i].ifid_we;
            Branch_taken  = vt[i].br;
            Branch_target = vt[i].tgt;
            imem_data     = vt[i].imem;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_addr", i),  imem_addr, vt[i].e_addr);
            check($sformatf("v%0d_instr", i), IFID_instr, vt[i].e_instr);
            check($sformatf("v%0d_pc4", i),   IFID_pc4, vt[i].e_pc4);
            check($sformatf("v%0d_valid", i), {31'd0, IFID_valid}, {31'd0, vt[i].e_valid});
            check($sformatf("v%0d_stall", i), {16'd0, stall_cycles}, {16'd0, exp_cnt(vt[i].e_stall)});
        end

        // async reset mid-stall: reach PC=8, stall, then drop rst_n between edges
        Branch_taken = 1'b0;
        rst_n = 1'b0;
        #1;
        check("ar0_addr", imem_addr, 32'h0);
        rst_n = 1'b1;
        PC_WriteEn = 1'b1; IFID_WriteEn = 1'b1; imem_data = 32'h9999_0000;
        repeat (2) @(posedge clk);
        #1;
        check("ar_pc8", imem_addr, 32'h8);
        PC_WriteEn = 1'b0; IFID_WriteEn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ar_hold", imem_addr, 32'h8);
        check("ar_stall_pre", {16'd0, stall_cycles}, {16'd0, exp_cnt(16'd2)});
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_addr",  imem_addr, 32'h0);
        check("ar_valid", {31'd0, IFID_valid}, 32'h0);
        check("ar_instr", IFID_instr, 32'h0);
        check("ar_pc4",   IFID_pc4, 32'h0);
        check("ar_stall", {16'd0, stall_cycles}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        PC_WriteEn = 1'b1; IFID_WriteEn = 1'b1; imem_data = 32'h2008_0005;
        @(posedge clk);
        #1;
        check("post_addr",  imem_addr, 32'h4);
        check("post_instr", IFID_instr, 32'h2008_0005);
        check("post_pc4",   IFID_pc4, 32'h4);

        // long stall: counter saturation on the narrow instance
        PC_WriteEn = 1'b0; IFID_WriteEn = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("long_hold",  imem_addr, 32'h4);
        check("long_instr", IFID_instr, 32'h2008_0005);
        check("long_stall", {16'd0, stall_cycles}, {16'd0, exp_cnt(16'd9)});
        check("sat_stall",  {29'd0, s_stall}, CNT_EN ? 32'd7 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
